// File: rtl/rib_timer_pkg.sv
// Shared definitions for the rib_timer slave: register offsets, CTRL bit
// positions, the rib slave slot, and the FSM state type.
package rib_timer_pkg;

    // Register offsets inside the decoded low address window
    localparam logic [31:0] TIMER_CTRL     = 32'h0000_0000;
    localparam logic [31:0] TIMER_PRESCALE = 32'h0000_0004;
    localparam logic [31:0] TIMER_COUNT    = 32'h0000_0008;
    localparam logic [31:0] TIMER_CMP      = 32'h0000_000C;
    localparam logic [31:0] TIMER_STATUS   = 32'h0000_0010;
    localparam logic [31:0] TIMER_CAPTURE  = 32'h0000_0014;

    // CTRL bit indices
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;

    // rib slave slot and address window occupied by the timer
    localparam logic [3:0]  TIMER_SLAVE_ID   = 4'd4;
    localparam logic [31:0] TIMER_SLAVE_BASE = 32'h4000_0000;
    localparam logic [31:0] TIMER_SLAVE_MASK = 32'hF000_0000;

    // Counter run state: IDLE while EN=0, RUN while EN=1
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // Assemble the CTRL read value from its three live bits
    function automatic logic [31:0] ctrl_word(input logic en, input logic auto_rl, input logic ie);
        ctrl_word = {29'd0, ie, auto_rl, en};
    endfunction

endpackage

// File: rtl/rib_timer_prescaler.sv
// timer_prescaler: counts 0..PRESCALE while enabled and emits a one-cycle
// tick when the count reaches PRESCALE. Held at 0 while disabled, cleared
// whenever software rewrites PRESCALE.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_pcnt;

    assign o_tick = i_en && (r_pcnt == i_prescale);

    // Prescale counter: wraps on tick, parked at 0 while disabled or on clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= {PRESCALE_W{1'b0}};
        end else if (i_clr || !i_en || o_tick) begin
            r_pcnt <= {PRESCALE_W{1'b0}};
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/rib_timer.sv
// rib_timer: 32-bit programmable timer slave on the rib bus.
// Optional build macro: TIMER_CAPTURE_EN adds a synchronised capture input
// that latches COUNT into CAPTURE and sets STATUS.CAPF.
module rib_timer
    import rib_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int ADDR_LSB_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wraddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        capture_pin,
    output logic        int_sig
);

    timer_state_e          r_state;
    timer_state_e          w_state_nxt;
    logic                  w_run;
    logic                  r_auto;
    logic                  r_ie;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count;
    logic [31:0]           r_cmp;
    logic                  r_pend;
    logic                  r_int;

    logic [31:0] w_off;
    logic        w_wr_ctrl, w_wr_pre, w_wr_count, w_wr_cmp, w_wr_status;
    logic        w_tick, w_match;
    logic        w_pend_nxt, w_ie_nxt, w_capf_nxt;
    logic        w_capf;
    logic [31:0] w_capture;

    // Upper address bits are ignored: rib has already selected this slave
    assign w_off       = wraddr & ((32'd1 << ADDR_LSB_W) - 32'd1);
    assign w_wr_ctrl   = we && (w_off == TIMER_CTRL);
    assign w_wr_pre    = we && (w_off == TIMER_PRESCALE);
    assign w_wr_count  = we && (w_off == TIMER_COUNT);
    assign w_wr_cmp    = we && (w_off == TIMER_CMP);
    assign w_wr_status = we && (w_off == TIMER_STATUS);

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_clr      (w_wr_pre),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // A software COUNT write overrides the tick, so no match is evaluated then
    assign w_match = w_tick && !w_wr_count && (r_count == r_cmp);

    // Run-state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next run state: CTRL writes win over a one-shot match stopping the timer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_ctrl && wdata[CTRL_EN_BIT]) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_wr_ctrl) begin
                    w_state_nxt = wdata[CTRL_EN_BIT] ? ST_RUN : ST_IDLE;
                end else if (w_match && !r_auto) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run-state decode: EN bit as seen by the prescaler and CTRL readback
    always_comb begin
        w_run = 1'b0;
        case (r_state)
            ST_RUN:  w_run = 1'b1;
            ST_IDLE: w_run = 1'b0;
            default: w_run = 1'b0;
        endcase
    end

    // Next PEND/IE: a match sets PEND even when a W1C lands in the same cycle
    always_comb begin
        w_pend_nxt = r_pend;
        w_ie_nxt   = r_ie;
        if (w_match) begin
            w_pend_nxt = 1'b1;
        end else if (w_wr_status && wdata[0]) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
        if (w_wr_ctrl) begin
            w_ie_nxt = wdata[CTRL_IE_BIT];
        end else begin
            w_ie_nxt = r_ie;
        end
    end

    // Register file, counter, pending flag and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= {PRESCALE_W{1'b0}};
            r_count    <= 32'd0;
            r_cmp      <= 32'd0;
            r_pend     <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_auto <= wdata[CTRL_AUTO_BIT];
            end
            if (w_wr_pre) begin
                r_prescale <= wdata[PRESCALE_W-1:0];
            end
            if (w_wr_cmp) begin
                r_cmp <= wdata;
            end
            if (w_wr_count) begin
                r_count <= wdata;
            end else if (w_match) begin
                r_count <= 32'd0;
            end else if (w_tick) begin
                r_count <= r_count + 32'd1;
            end
            r_ie   <= w_ie_nxt;
            r_pend <= w_pend_nxt;
            r_int  <= (w_pend_nxt | w_capf_nxt) & w_ie_nxt;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic        r_sync1, r_sync2, r_sync_d;
    logic        r_capf;
    logic [31:0] r_capture;
    logic        w_cap_edge;

    assign w_cap_edge = r_sync2 && !r_sync_d;

    // Next CAPF: an edge sets it even when a W1C lands in the same cycle
    always_comb begin
        w_capf_nxt = r_capf;
        if (w_cap_edge) begin
            w_capf_nxt = 1'b1;
        end else if (w_wr_status && wdata[1]) begin
            w_capf_nxt = 1'b0;
        end else begin
            w_capf_nxt = r_capf;
        end
    end

    // Pin synchroniser, edge history, capture register and CAPF
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync_d  <= 1'b0;
            r_capf    <= 1'b0;
            r_capture <= 32'd0;
        end else begin
            r_sync1  <= capture_pin;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_capf   <= w_capf_nxt;
            if (w_cap_edge) begin
                r_capture <= r_count;
            end
        end
    end

    assign w_capf    = r_capf;
    assign w_capture = r_capture;
`else
    logic w_unused_capture_pin;
    assign w_unused_capture_pin = capture_pin;
    assign w_capf_nxt = 1'b0;
    assign w_capf     = 1'b0;
    assign w_capture  = 32'd0;
`endif

    // Zero-latency read mux; unmapped offsets read 0
    always_comb begin
        rdata = 32'd0;
        case (w_off)
            TIMER_CTRL:     rdata = ctrl_word(w_run, r_auto, r_ie);
            TIMER_PRESCALE: rdata = {{(32-PRESCALE_W){1'b0}}, r_prescale};
            TIMER_COUNT:    rdata = r_count;
            TIMER_CMP:      rdata = r_cmp;
            TIMER_STATUS:   rdata = {30'd0, w_capf, r_pend};
            TIMER_CAPTURE:  rdata = w_capture;
            default:        rdata = 32'd0;
        endcase
    end

    assign int_sig = r_int;

endmodule
